// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, slave FSM states and byte-lane mask helper
package ahb_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_t;
  typedef enum logic [2:0] {HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD} hsize_t;
  typedef enum logic [2:0] {
    HBURST_SINGLE, HBURST_INCR, HBURST_WRAP4, HBURST_INCR4,
    HBURST_WRAP8, HBURST_INCR8, HBURST_WRAP16, HBURST_INCR16
  } hburst_t;
  typedef enum logic {HRESP_OKAY, HRESP_ERROR} hresp_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
  // little-endian lane mask: 2^size contiguous lanes starting at byte offset off
  function automatic logic [7:0] byte_mask(input logic [2:0] off, input logic [1:0] size);
    return 8'(((16'd1 << (4'd1 << size)) - 16'd1) << off);
  endfunction
endpackage

// File: rtl/ahb_mem_array.sv
// ahb_mem_array: MEM_DEPTH x DATA_WIDTH storage, per-byte write enable, combinational read
// ports: clk_i clock; we_i write strobe; be_i byte enables; addr_i word index;
//        wdata_i write word; rdata_o word at addr_i
module ahb_mem_array
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [DATA_WIDTH/8-1:0]      be_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  output logic [DATA_WIDTH-1:0]        rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  always_ff @(posedge clk_i)
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (we_i && be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: pipelined AHB-Lite memory slave with wait states, byte lanes and 2-cycle ERROR
// ports: hclk_i/hresetn_i clock and async active-low reset; hsel_i, haddr_i, htrans_i, hwrite_i,
//        hsize_i, hburst_i, hprot_i, hready_i address phase; hwdata_i write data;
//        hreadyout_o, hresp_o, hrdata_o data phase response
// optional: define AHB_MEM_PROT_EN to reject user-mode writes to the upper half of memory
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk_i,
  input  logic                  hresetn_i,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [3:0]            hprot_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  input  logic                  hready_i,
  output logic                  hreadyout_o,
  output logic                  hresp_o,
  output logic [DATA_WIDTH-1:0] hrdata_o
);
  localparam int BYTES = DATA_WIDTH/8;
  localparam int OFF = $clog2(BYTES);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH*BYTES);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES-1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [OFF+IW-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic write_q, write_d, err_q, err_d, valid_q, valid_d;
  logic accept, illegal, prot_err, phase_end, commit, rd_phase;
  logic [2:0] align_mask;
  logic [BYTES-1:0] be;
  logic [DATA_WIDTH-1:0] rdata;
  logic unused;
  assign unused = ^{hburst_i, hprot_i, htrans_i[0]};
  assign accept = hsel_i && hready_i && htrans_i[1];
  assign align_mask = 3'((4'd1 << hsize_i[1:0]) - 4'd1);
`ifdef AHB_MEM_PROT_EN
  assign prot_err = hwrite_i && !hprot_i[1] && ((haddr_i >> OFF) >= ADDR_WIDTH'(MEM_DEPTH/2));
`else
  assign prot_err = 1'b0;
`endif
  assign illegal = ({1'b0, haddr_i} >= MEM_BYTES) || (hsize_i > 3'(OFF)) ||
                   ((align_mask & haddr_i[2:0]) != 3'd0) || prot_err;
  // IDLE and ERR2 are the cycles in which any outstanding data phase completes
  assign phase_end = state_q == ST_IDLE || state_q == ST_ERR2;
  assign commit = state_q == ST_IDLE && valid_q && write_q && !err_q;
  assign rd_phase = valid_q && !write_q && !err_q && (state_q == ST_IDLE || state_q == ST_WAIT);
  assign be = BYTES'(byte_mask(3'(addr_q[OFF-1:0]), size_q));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    size_d = size_q;
    write_d = write_q;
    err_d = err_q;
    valid_d = valid_q;
    if (phase_end) begin
      valid_d = accept;
      state_d = ST_IDLE;
      if (accept) begin
        addr_d = haddr_i[OFF+IW-1:0];
        size_d = hsize_i[1:0];
        write_d = hwrite_i;
        err_d = illegal;
        state_d = illegal ? ST_ERR1 : (WAIT_STATES > 0 ? ST_WAIT : ST_IDLE);
        cnt_d = CNT_INIT;
      end
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      state_d = cnt_q == 4'd0 ? ST_IDLE : ST_WAIT;
    end else begin
      state_d = ST_ERR2;
    end
  end
  always_ff @(posedge hclk_i or negedge hresetn_i)
    if (!hresetn_i) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      size_q <= size_d;
      write_q <= write_d;
      err_q <= err_d;
      valid_q <= valid_d;
    end
  // writes land at the end of their data phase, so a following read sees them combinationally
  ahb_mem_array #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk_i(hclk_i),
    .we_i(commit),
    .be_i(be),
    .addr_i(addr_q[OFF+IW-1:OFF]),
    .wdata_i(hwdata_i),
    .rdata_o(rdata)
  );
  assign hreadyout_o = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign hresp_o = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata_o = rd_phase ? rdata : '0;
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// tb_ahb_lite_mem_slave: scoreboard bench driving a zero-wait and a three-wait slave over one muxed bus
module tb_ahb_lite_mem_slave;
`ifdef AHB_MEM_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif
  typedef struct {logic resp; logic [31:0] data; int waits;} exp_t;
  logic clk = 0, hresetn = 0, hsel = 0, hwrite = 0, dsel = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 0, hburst = 0;
  logic [3:0] hprot = 4'b0011;
  logic rdy0, rdy1, rsp0, rsp1, hreadyout, hresp;
  logic [31:0] rd0, rd1, hrdata;
  exp_t sbq[$];
  exp_t mon_e;
  logic [31:0] model [int];
  logic [31:0] saved;
  int checks = 0, errors = 0, low = 0;
  bit dp = 0;
  always #5 clk = ~clk;
  assign hreadyout = dsel ? rdy1 : rdy0;
  assign hresp = dsel ? rsp1 : rsp0;
  assign hrdata = dsel ? rd1 : rd0;
  ahb_lite_mem_slave #(.WAIT_STATES(0)) dut0 (
    .hclk_i(clk), .hresetn_i(hresetn), .hsel_i(hsel && !dsel), .haddr_i(haddr),
    .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
    .hprot_i(hprot), .hwdata_i(hwdata), .hready_i(rdy0),
    .hreadyout_o(rdy0), .hresp_o(rsp0), .hrdata_o(rd0)
  );
  ahb_lite_mem_slave #(.WAIT_STATES(3)) dut3 (
    .hclk_i(clk), .hresetn_i(hresetn), .hsel_i(hsel && dsel), .haddr_i(haddr),
    .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst),
    .hprot_i(hprot), .hwdata_i(hwdata), .hready_i(rdy1),
    .hreadyout_o(rdy1), .hresp_o(rsp1), .hrdata_o(rd1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // data-phase monitor: counts low cycles and scores each completing phase
  always @(negedge clk) begin
    if (!hresetn) begin
      sbq.delete();
      dp = 0;
      low = 0;
    end else begin
      if (dp && !hreadyout) begin
        low++;
        if (sbq.size() > 0) chk("resp_wait", hresp, sbq[0].resp);
      end else if (dp) begin
        chk("sb_nonempty", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          mon_e = sbq.pop_front();
          chk("resp", hresp, mon_e.resp);
          chk("rdata", hrdata, mon_e.data);
          chk("waits", low, mon_e.waits);
        end
        dp = 0;
        low = 0;
      end
      if (hsel && hreadyout && htrans[1]) dp = 1;
    end
  end
  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] d, input logic [3:0] prot);
    exp_t e;
    int n, k;
    logic r, legal;
    logic [31:0] word;
    legal = a < 32'h1000 && sz <= 3'd2 && (a & ((32'd1 << sz) - 32'd1)) == 0;
    if (PROT_EN && w && !prot[1] && a >= 32'h800) legal = 0;
    haddr = a; hwrite = w; hsize = sz; hprot = prot; htrans = 2'b10; hsel = 1;
    n = 0;
    do begin
      @(negedge clk) r = hreadyout;
      @(posedge clk) n++;
    end while (!r && n < 50);
    chk("accept", r, 1);
    #1 hwdata = d;
    k = int'(dsel) * 4096 + int'(a >> 2);
    e.resp = !legal;
    e.waits = legal ? (dsel ? 3 : 0) : 1;
    e.data = 0;
    if (legal && !w) e.data = model[k];
    if (legal && w) begin
      word = model.exists(k) ? model[k] : 32'h0;
      for (int i = 0; i < (1 << sz); i++) word[8*(a[1:0]+i) +: 8] = d[8*(a[1:0]+i) +: 8];
      model[k] = word;
    end
    sbq.push_back(e);
  endtask
  task automatic idle(input int n);
    htrans = 0; hsel = 0; hwrite = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy0", rdy0, 1); chk("rst_resp0", rsp0, 0); chk("rst_rdata0", rd0, 0);
    chk("rst_rdy3", rdy1, 1); chk("rst_resp3", rsp1, 0); chk("rst_rdata3", rd1, 0);
    hresetn = 1;
    issue(32'h10, 1, 2, 32'hDEADBEEF, 4'b0011);
    issue(32'h10, 0, 2, 32'h0, 4'b0011);
    issue(32'h00, 1, 2, 32'h0BADF00D, 4'b0011);
    issue(32'h10, 1, 2, 32'h11223344, 4'b0011);
    issue(32'h13, 1, 0, 32'hAA5A5A5A, 4'b0011);
    issue(32'h10, 0, 2, 32'h0, 4'b0011);
    issue(32'h1000, 0, 2, 32'h0, 4'b0011);
    issue(32'h01, 1, 1, 32'hFFFFFFFF, 4'b0011);
    issue(32'h00, 0, 2, 32'h0, 4'b0011);
    issue(32'h10, 0, 3, 32'h0, 4'b0011);
    issue(32'h800, 1, 2, 32'h55AA55AA, 4'b0011);
    issue(32'h800, 1, 2, 32'h12345678, 4'b0001);
    issue(32'h800, 1, 2, 32'h0F0F0F0F, 4'b0011);
    issue(32'h800, 0, 2, 32'h0, 4'b0011);
    issue(32'h800, 1, 2, 32'hCAFEF00D, 4'b0001);
    issue(32'h800, 0, 2, 32'h0, 4'b0011);
    issue(32'h12, 0, 0, 32'h0, 4'b0011);
    idle(4);
    dsel = 1;
    #1;
    issue(32'h10, 1, 2, 32'h12345678, 4'b0011);
    issue(32'h10, 0, 2, 32'h0, 4'b0011);
    issue(32'h14, 1, 2, 32'h9ABCDEF0, 4'b0011);
    issue(32'h14, 0, 2, 32'h0, 4'b0011);
    issue(32'h2000, 0, 2, 32'h0, 4'b0011);
    issue(32'h10, 0, 2, 32'h0, 4'b0011);
    idle(8);
    saved = model[4096 + 4];
    issue(32'h10, 1, 2, 32'hFFFF0000, 4'b0011);
    model[4096 + 4] = saved;
    htrans = 0; hsel = 0; hwrite = 0;
    @(posedge clk);
    #3 hresetn = 0;
    #1;
    chk("midrst_rdy", hreadyout, 1); chk("midrst_resp", hresp, 0); chk("midrst_rdata", hrdata, 0);
    repeat (2) @(posedge clk);
    #1 hresetn = 1;
    issue(32'h10, 0, 2, 32'h0, 4'b0011);
    idle(8);
    chk("drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
Parametrised AHB-Lite slave memory for the AHB VIP environment, acting as the DUT-side responder behind the ahb_if slave modport.
- Generalises the plain slave role to configurable data width, depth and programmable wait states.
- Supports HSIZE byte-lane writes and a two-cycle ERROR response for illegal accesses.
- Fully pipelined: a new address phase overlaps the current data phase.

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HWDATA/HRDATA width; legal values are 32 and 64
MEM_DEPTH, 1024, number of DATA_WIDTH-bit words
WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; range 0..15

Ports:
hclk       input   1           bus clock
hresetn    input   1           asynchronous active-low reset
hsel       input   1           slave select
haddr      input   ADDR_WIDTH  transfer address
htrans     input   2           IDLE/BUSY/NONSEQ/SEQ
hwrite     input   1           1 = write
hsize      input   3           transfer size
hburst     input   3           burst type; accepted but not decoded
hprot      input   4           protection control
hwdata     input   DATA_WIDTH  write data, valid in data phase
hready     input   1           bus HREADY; qualifies the address phase
hreadyout  output  1           slave ready
hresp      output  1           0 = OKAY, 1 = ERROR
hrdata     output  DATA_WIDTH  read data

Behaviour:
- Clock and reset: single clock hclk. Reset hresetn is asynchronous and active-low.
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Accept: an address phase is accepted on a rising edge with hsel && hready && htrans[1]. On accept, register addr, write, size and the error flag.
- IDLE/BUSY: with hsel, get a zero-wait OKAY and no state change.
- Legality: an access is illegal (error flag set) if any of the following holds:
  - haddr >= MEM_DEPTH*(DATA_WIDTH/8)
  - hsize > log2(DATA_WIDTH/8)
  - haddr is not aligned to 2^hsize
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE: hreadyout=1. On a legal accept with WAIT_STATES>0, go to WAIT with cnt=WAIT_STATES-1. On a legal accept with WAIT_STATES=0, stay in IDLE; the data phase completes next cycle. On an illegal accept, go to ERR1.
- WAIT: hreadyout=0, hresp=0. Decrement cnt. At cnt==0, the next cycle is the completing cycle (hreadyout=1), then the FSM returns to accept handling.
- ERR1: hreadyout=0, hresp=1.
- ERR2: hreadyout=1, hresp=1. An accept in this cycle is honoured as from IDLE; otherwise go to IDLE.
- Writes: commit on the edge ending the data phase (hreadyout=1).
  - Little-endian byte enables from addr[log2(DATA_WIDTH/8)-1:0] and size.
  - Only the enabled lanes are written. Illegal writes never modify memory.
- Reads: during the data phase, hrdata = full word at addr_q regardless of size. hrdata=0 outside a read data phase and on ERROR.
- Read-after-write: a read whose data phase directly follows a write to the same word returns the new data.
- Latency: an OKAY data phase lasts WAIT_STATES+1 cycles. An ERROR data phase lasts exactly 2 cycles.
- Back-to-back: an accept in the completing cycle starts the next data phase with no bubble.
- Reset mid-transfer: pending write is dropped and outputs return to reset values immediately.

Optional Feature:
AHB_MEM_PROT_EN
- Defined: a write with hprot[1]==0 (user) to the upper half of memory (word index >= MEM_DEPTH/2) is illegal. It gets a two-cycle ERROR and memory is unchanged.
- Undefined: hprot is ignored.

Decomposition:
- Package ahb_pkg holds:
  - htrans_t, hsize_t, hburst_t, hresp_t enums
  - FSM state enum
  - function for byte-enable mask from (addr, size)
- Sub-module ahb_mem_array: MEM_DEPTH x DATA_WIDTH storage with per-byte write enable and combinational read.

Test Plan:
- Reset: assert hresetn=0 mid-WAIT -> hreadyout=1, hresp=0, hrdata=0 the same cycle; the pending write to 0x10 leaves memory unchanged.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF @0x10, then read @0x10 pipelined -> hreadyout never low; hrdata=0xDEADBEEF in the cycle after the read address.
- Byte lanes: write byte 0xAA @0x13 over 0x11223344 -> a word read of 0x10 returns 0xAA223344.
- WAIT_STATES=3: a single read -> hreadyout low exactly 3 cycles, then high with data; the next NONSEQ is accepted in the completing cycle.
- Errors:
  - Read @MEM_DEPTH*4 -> hresp=1 for 2 cycles, hreadyout 0 then 1.
  - Halfword write @0x01 -> the same ERROR sequence, and memory is unchanged.
- AHB_MEM_PROT_EN: user write (hprot=4'b0001) to word MEM_DEPTH/2 -> ERROR. The same write with hprot=4'b0011 -> OKAY.
